// File: rtl/ball_engine_if.sv
// ball_engine_if: groups the playfield-side signals of ball_engine.
// The slave modport is the engine's view; master is the driving/consuming side.
`timescale 1ns/1ps
`default_nettype none
interface ball_engine_if;
  logic       start;
  logic [2:0] player_left;
  logic [2:0] player_right;
  logic [7:0] near;
  logic [2:0] count;
  logic [5:0] pos_ball;
  logic       miss_valid;
  logic [1:0] miss_side;
  logic       playing;

  modport slave (
    input  start, player_left, player_right, near,
    output count, pos_ball, miss_valid, miss_side, playing
  );

  modport master (
    output start, player_left, player_right, near,
    input  count, pos_ball, miss_valid, miss_side, playing
  );
endinterface
`default_nettype wire

// File: rtl/ball_engine.sv
// ball_engine: row-scan counter, ball motion, paddle/wall bounce and miss sequencing.
// Revision 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none
module ball_engine #(
  parameter int SIZE            = 2,
  parameter int WIDTH           = 8,
  parameter int FRAMES_PER_STEP = 16,
  parameter int HOLD_FRAMES     = 32
) (
  input logic         clk,
  input logic         rst_n,
  ball_engine_if.slave bus
);
  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_MISS  = 2'd2;

  localparam logic [7:0]        C_FPS_LAST  = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0]        C_HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [2:0]        C_CENTER    = 3'd3;
  localparam logic [2:0]        C_EDGE_HI   = 3'(WIDTH - 1);
  localparam logic [2:0]        C_LAST_IN   = 3'(WIDTH - 2);
  localparam logic [2:0]        C_BOUNCE_HI = 3'(WIDTH - 3);
  localparam logic signed [4:0] C_SIZE      = 5'(SIZE);
  localparam logic signed [4:0] C_W2        = 5'(WIDTH - 2);
  localparam logic signed [4:0] C_W3        = 5'(WIDTH - 3);

  logic [1:0] r_state;
  logic [2:0] r_count;
  logic [7:0] r_frame;
  logic [7:0] r_hold;
  logic [2:0] r_x, r_y;
  logic       r_dx, r_dy;
  logic [1:0] r_serve_cnt;
  logic [2:0] r_bot_nb;
  logic       r_miss_valid;
  logic [1:0] r_miss_side;
  logic       r_playing;

  function automatic logic f_occ(input logic signed [4:0] r,
                                 input logic signed [4:0] lo,
                                 input logic signed [4:0] hi);
    return (r >= lo) && (r <= hi);
  endfunction

  logic w_edge1, w_move;
  logic w_top_chk, w_bot_chk, w_left_chk, w_right_chk;
  logic w_top_hit, w_bot_hit, w_left_hit, w_right_hit;
  logic w_v_miss, w_h_miss;
  logic signed [4:0] w_y_s, w_y_nb, w_l_lo, w_l_hi, w_r_lo, w_r_hi;
  logic [2:0] w_nx, w_ny;
  logic       w_ndx, w_ndy;
  logic [1:0] w_side;
  logic       w_unused_near;

  assign w_unused_near = &{1'b0, bus.near[4:3]};

  assign w_edge1 = (r_count == 3'd1);
  assign w_move  = (r_state == S_PLAY) && w_edge1 && (r_frame == C_FPS_LAST);

  // Top row comes live from game_process; bottom row was captured at count==0.
  assign w_top_chk = (r_y == 3'd1) && !r_dy;
  assign w_bot_chk = (r_y == C_LAST_IN) && r_dy;
  assign w_top_hit = bus.near[1] | (r_dx ? bus.near[2] : bus.near[0]);
  assign w_bot_hit = r_bot_nb[1] | (r_dx ? r_bot_nb[2] : r_bot_nb[0]);

  assign w_y_s  = $signed({2'b00, r_y});
  assign w_y_nb = r_dy ? (w_y_s + 5'sd1) : (w_y_s - 5'sd1);
  assign w_l_lo = $signed({2'b00, bus.player_left});
  assign w_l_hi = w_l_lo + C_SIZE - 5'sd1;
  assign w_r_lo = C_W2 - $signed({2'b00, bus.player_right});
  assign w_r_hi = C_W3 - $signed({2'b00, bus.player_right}) + C_SIZE;

  assign w_left_chk  = (r_x == 3'd1) && !r_dx;
  assign w_right_chk = (r_x == C_LAST_IN) && r_dx;
  assign w_left_hit  = f_occ(w_y_s, w_l_lo, w_l_hi) | f_occ(w_y_nb, w_l_lo, w_l_hi);
  assign w_right_hit = f_occ(w_y_s, w_r_lo, w_r_hi) | f_occ(w_y_nb, w_r_lo, w_r_hi);

  assign w_v_miss = (w_top_chk && !w_top_hit) || (w_bot_chk && !w_bot_hit);
  assign w_h_miss = (w_left_chk && !w_left_hit) || (w_right_chk && !w_right_hit);

  always_comb begin
    w_ny  = r_dy ? (r_y + 3'd1) : (r_y - 3'd1);
    w_ndy = r_dy;
    if (w_top_chk) begin
      if (w_top_hit) begin
        w_ny  = 3'd2;
        w_ndy = 1'b1;
      end else begin
        w_ny = 3'd0;
      end
    end else if (w_bot_chk) begin
      if (w_bot_hit) begin
        w_ny  = C_BOUNCE_HI;
        w_ndy = 1'b0;
      end else begin
        w_ny = C_EDGE_HI;
      end
    end
  end

  always_comb begin
    w_nx  = r_dx ? (r_x + 3'd1) : (r_x - 3'd1);
    w_ndx = r_dx;
    if (w_left_chk) begin
      if (w_left_hit) begin
        w_nx  = 3'd2;
        w_ndx = 1'b1;
      end else begin
        w_nx = 3'd0;
      end
    end else if (w_right_chk) begin
      if (w_right_hit) begin
        w_nx  = C_BOUNCE_HI;
        w_ndx = 1'b0;
      end else begin
        w_nx = C_EDGE_HI;
      end
    end
  end

  // Vertical side wins when both axes miss on the same move.
  always_comb begin
    w_side = 2'd3;
    if (w_top_chk && !w_top_hit)        w_side = 2'd0;
    else if (w_bot_chk && !w_bot_hit)   w_side = 2'd1;
    else if (w_left_chk && !w_left_hit) w_side = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_SERVE;
      r_count      <= 3'd0;
      r_frame      <= 8'd0;
      r_hold       <= 8'd0;
      r_x          <= C_CENTER;
      r_y          <= C_CENTER;
      r_dx         <= 1'b1;
      r_dy         <= 1'b1;
      r_serve_cnt  <= 2'd0;
      r_bot_nb     <= 3'd0;
      r_miss_valid <= 1'b0;
      r_miss_side  <= 2'd0;
      r_playing    <= 1'b0;
    end else begin
      r_count      <= r_count + 3'd1;
      r_miss_valid <= 1'b0;
      if (r_count == 3'd0) r_bot_nb <= bus.near[7:5];
      case (r_state)
        S_SERVE: begin
          if (bus.start) begin
            {r_dx, r_dy} <= r_serve_cnt;
            r_serve_cnt  <= r_serve_cnt + 2'd1;
            r_frame      <= 8'd0;
            r_state      <= S_PLAY;
            r_playing    <= 1'b1;
          end
        end
        S_PLAY: begin
          if (w_edge1) r_frame <= (r_frame == C_FPS_LAST) ? 8'd0 : r_frame + 8'd1;
          if (w_move) begin
            r_x  <= w_nx;
            r_y  <= w_ny;
            r_dx <= w_ndx;
            r_dy <= w_ndy;
            if (w_v_miss || w_h_miss) begin
              r_miss_valid <= 1'b1;
              r_miss_side  <= w_side;
              r_hold       <= 8'd0;
              r_state      <= S_MISS;
              r_playing    <= 1'b0;
            end
          end
        end
        S_MISS: begin
          if (w_edge1) begin
            if (r_hold == C_HOLD_LAST) begin
              r_hold  <= 8'd0;
              r_x     <= C_CENTER;
              r_y     <= C_CENTER;
              r_state <= S_SERVE;
            end else begin
              r_hold <= r_hold + 8'd1;
            end
          end
        end
        default: begin
          r_state   <= S_SERVE;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count      = r_count;
  assign bus.pos_ball   = {r_x, r_y};
  assign bus.miss_valid = r_miss_valid;
  assign bus.miss_side  = r_miss_side;
  assign bus.playing    = r_playing;
endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
// tb_ball_engine: step table of ball moves fed to a scoreboard, checked as positions change.
`timescale 1ns/1ps
`default_nettype none
module tb_ball_engine;
  localparam int FPS  = 2;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ball_engine_if bus();
  ball_engine #(.SIZE(2), .WIDTH(8), .FRAMES_PER_STEP(FPS), .HOLD_FRAMES(HOLD))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic       serve;
    logic [7:0] near;
    logic [2:0] pl;
    logic [2:0] pr;
    logic [5:0] pos;
    logic       miss;
    logic [1:0] side;
    logic       ex;
  } step_t;

  typedef struct {
    logic [5:0] pos;
    logic       miss;
    logic [1:0] side;
    logic       play;
    logic       ex;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;
  logic [5:0] last_pos = 6'o33;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic step_t mk(input logic s, input logic [7:0] n, input logic [2:0] pl,
                               input logic [2:0] pr, input logic [5:0] pos,
                               input logic m, input logic [1:0] sd, input logic ex);
    step_t t;
    t.serve = s; t.near = n; t.pl = pl; t.pr = pr;
    t.pos = pos; t.miss = m; t.side = sd; t.ex = ex;
    return t;
  endfunction

  // Monitor: every position change consumes one scoreboard entry.
  initial begin
    logic pm;
    int   fs;
    exp_t e;
    pm = 1'b0;
    fs = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (bus.count == 3'd2) fs++;
        if (pm) check("miss_one_cycle", bus.miss_valid, 0);
        else if (bus.pos_ball == last_pos && bus.miss_valid) fail_now("spurious_miss");
        pm = 1'b0;
        if (bus.pos_ball != last_pos) begin
          last_pos = bus.pos_ball;
          if (sb.size() == 0) begin
            fail_now("unexpected_move");
          end else begin
            e = sb.pop_front();
            check("pos", bus.pos_ball, e.pos);
            check("miss_valid", bus.miss_valid, e.miss);
            check("miss_side", bus.miss_side, e.side);
            check("playing", bus.playing, e.play);
            check("move_count_phase", bus.count, 2);
            if (e.ex) check("hold_frames", fs, HOLD);
            pm = bus.miss_valid;
          end
          fs = 0;
        end
      end else begin
        pm = 1'b0;
        fs = 0;
      end
    end
  end

  task automatic do_serve();
    int  k;
    bit  ok;
    k  = 0;
    ok = 1'b0;
    bus.start = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.playing) begin ok = 1'b1; break; end
    end
    bus.start = 1'b0;
    if (!ok) fail_now("serve_timeout");
    check("serve_pos", bus.pos_ball, 6'o33);
    for (int t = 0; t < FPS * 8 + 16; t++) begin
      @(negedge clk);
      if (bus.count == 3'd2) k++;
      if (bus.pos_ball != 6'o33) break;
    end
    check("first_move_frames", k, FPS);
  endtask

  task automatic run_step(input step_t s);
    exp_t e;
    bus.near = s.near;
    bus.player_left = s.pl;
    bus.player_right = s.pr;
    e.pos = s.pos; e.miss = s.miss; e.side = s.side;
    e.play = !(s.miss | s.ex); e.ex = s.ex;
    sb.push_back(e);
    if (s.serve) do_serve();
    for (int t = 0; t < 400; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      fail_now("step_timeout");
      sb.delete();
    end
    #1;
  endtask

  task automatic reset_check(input logic [1:0] side_before);
    mon_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_pos", bus.pos_ball, 6'o33);
    check("rst_miss_valid", bus.miss_valid, 0);
    check("rst_playing", bus.playing, 0);
    check("rst_miss_side", bus.miss_side, 0);
    if (side_before != 2'd0) check("rst_side_changed", bus.miss_side, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    last_pos = 6'o33;
    mon_en = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.near = 8'h00;
    bus.player_left = 3'd0;
    bus.player_right = 3'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("init_count", bus.count, 0);
    check("init_pos", bus.pos_ball, 6'o33);
    check("init_playing", bus.playing, 0);
    @(negedge clk);
    check("count_step", bus.count, 1);
    repeat (4) @(posedge clk);
    reset_check(2'd0);

    // serve 1: dx=0 dy=0
    steps.push_back(mk(1, 8'h00, 0, 0, 6'o22, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 0, 6'o11, 0, 0, 0));
    steps.push_back(mk(0, 8'h01, 0, 0, 6'o22, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 0, 6'o33, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 0, 6'o44, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 0, 6'o55, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 0, 6'o66, 0, 0, 0));
    steps.push_back(mk(0, 8'h40, 0, 0, 6'o55, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 4, 0, 6'o44, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 4, 0, 6'o33, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 4, 0, 6'o22, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 4, 0, 6'o11, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 4, 0, 6'o00, 1, 0, 0));
    steps.push_back(mk(0, 8'h00, 4, 0, 6'o33, 0, 0, 1));
    // serve 2: dx=0 dy=1
    steps.push_back(mk(1, 8'h00, 6, 0, 6'o24, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 6, 0, 6'o15, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 6, 0, 6'o26, 0, 0, 0));
    steps.push_back(mk(0, 8'h80, 6, 0, 6'o35, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 6, 6, 6'o44, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 6, 6, 6'o53, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 6, 6, 6'o62, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 6, 6, 6'o51, 0, 0, 0));
    steps.push_back(mk(0, 8'h02, 0, 6, 6'o42, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 6, 6'o33, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 6, 6'o24, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 6, 6'o15, 0, 0, 0));
    steps.push_back(mk(0, 8'h00, 0, 6, 6'o06, 1, 2, 0));
    steps.push_back(mk(0, 8'h00, 0, 6, 6'o33, 0, 2, 1));
    // serve 3: dx=1 dy=0
    steps.push_back(mk(1, 8'h00, 0, 7, 6'o42, 0, 2, 0));
    steps.push_back(mk(0, 8'h00, 0, 7, 6'o51, 0, 2, 0));
    steps.push_back(mk(0, 8'h04, 0, 7, 6'o62, 0, 2, 0));
    steps.push_back(mk(0, 8'h00, 0, 7, 6'o73, 1, 3, 0));
    steps.push_back(mk(0, 8'h00, 0, 7, 6'o33, 0, 3, 1));
    // serve 4: dx=1 dy=1, then corner double miss
    steps.push_back(mk(1, 8'h00, 0, 7, 6'o44, 0, 3, 0));
    steps.push_back(mk(0, 8'h00, 0, 7, 6'o55, 0, 3, 0));
    steps.push_back(mk(0, 8'h00, 0, 7, 6'o66, 0, 3, 0));
    steps.push_back(mk(0, 8'h00, 0, 7, 6'o77, 1, 1, 0));
    steps.push_back(mk(0, 8'h00, 0, 7, 6'o33, 0, 1, 1));
    // serve 5: serve counter wrapped back to dx=0 dy=0
    steps.push_back(mk(1, 8'h00, 0, 7, 6'o22, 0, 1, 0));

    mon_en = 1'b1;
    foreach (steps[i]) run_step(steps[i]);

    repeat (3) @(posedge clk);
    reset_check(bus.miss_side);
    run_step(mk(1, 8'h00, 0, 7, 6'o22, 0, 0, 0));

    repeat (4) @(posedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
